// File: rtl/branch_seq.sv
// Relative conditional-branch sequencer: resolves taken/not-taken, page-cross fixup and cycle count.
// Optional macro BRANCH_SEQ_DUMMY_FETCH_EN models the dummy operand reads made during ADD/FIX.
module branch_seq (
    input  logic        CLK,
    input  logic        RES,
    input  logic        BR_START,
    input  logic        n_BRTAKEN,
    input  logic [7:0]  OFFSET,
    input  logic [15:0] PC_IN,
    input  logic        RDY,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] PC_OUT,
    output logic [2:0]  CYCLES,
    output logic        PAGE_X,
    output logic        DUMMY_RD,
    output logic [15:0] DUMMY_ADDR
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_reg;
    logic [15:0] pc_reg;
    logic [7:0]  off_reg;
    logic        brfw_reg;
    logic [7:0]  lo_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [15:0] pc_out_reg;
    logic [2:0]  cycles_reg;
    logic        page_x_reg;

    // Low-byte add as an explicit ripple chain so the carry out is directly visible.
    logic [8:0]  carry;
    logic [7:0]  sum_lo;
    logic        page_cross;
    logic [7:0]  hi_fix;

    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_lo_add
            assign sum_lo[gi]    = pc_reg[gi] ^ off_reg[gi] ^ carry[gi];
            assign carry[gi + 1] = (pc_reg[gi] & off_reg[gi]) |
                                   (carry[gi] & (pc_reg[gi] ^ off_reg[gi]));
        end
    endgenerate

    // Forward branches cross on carry; backward branches cross when no carry (borrow).
    assign page_cross = brfw_reg ? carry[8] : ~carry[8];
    assign hi_fix     = brfw_reg ? (pc_reg[15:8] + 8'd1) : (pc_reg[15:8] - 8'd1);

`ifdef BRANCH_SEQ_DUMMY_FETCH_EN
    logic        dummy_rd_reg;
    logic [15:0] dummy_addr_reg;
`endif

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= 16'h0000;
            off_reg        <= 8'h00;
            brfw_reg       <= 1'b0;
            lo_reg         <= 8'h00;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            pc_out_reg     <= 16'h0000;
            cycles_reg     <= 3'd0;
            page_x_reg     <= 1'b0;
`ifdef BRANCH_SEQ_DUMMY_FETCH_EN
            dummy_rd_reg   <= 1'b0;
            dummy_addr_reg <= 16'h0000;
`endif
        end else if (RDY) begin
            case (state_reg)
                ST_IDLE: begin
                    if (BR_START) begin
                        pc_reg   <= PC_IN;
                        off_reg  <= OFFSET;
                        brfw_reg <= ~OFFSET[7];
                        busy_reg <= 1'b1;
                        if (n_BRTAKEN) begin
                            state_reg  <= ST_DONE;
                            done_reg   <= 1'b1;
                            pc_out_reg <= PC_IN;
                            cycles_reg <= 3'd2;
                            page_x_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_ADD;
`ifdef BRANCH_SEQ_DUMMY_FETCH_EN
                            dummy_rd_reg   <= 1'b1;
                            dummy_addr_reg <= PC_IN;
`endif
                        end
                    end
                end

                ST_ADD: begin
                    lo_reg <= sum_lo;
                    if (page_cross) begin
                        state_reg <= ST_FIX;
`ifdef BRANCH_SEQ_DUMMY_FETCH_EN
                        // The real CPU reads from the uncorrected page first.
                        dummy_addr_reg <= {pc_reg[15:8], sum_lo};
`endif
                    end else begin
                        state_reg  <= ST_DONE;
                        done_reg   <= 1'b1;
                        pc_out_reg <= {pc_reg[15:8], sum_lo};
                        cycles_reg <= 3'd3;
                        page_x_reg <= 1'b0;
`ifdef BRANCH_SEQ_DUMMY_FETCH_EN
                        dummy_rd_reg   <= 1'b0;
                        dummy_addr_reg <= 16'h0000;
`endif
                    end
                end

                ST_FIX: begin
                    state_reg  <= ST_DONE;
                    done_reg   <= 1'b1;
                    pc_out_reg <= {hi_fix, lo_reg};
                    cycles_reg <= 3'd4;
                    page_x_reg <= 1'b1;
`ifdef BRANCH_SEQ_DUMMY_FETCH_EN
                    dummy_rd_reg   <= 1'b0;
                    dummy_addr_reg <= 16'h0000;
`endif
                end

                ST_DONE: begin
                    // Returning to IDLE only; a start request is first seen next cycle.
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY   = busy_reg;
    assign DONE   = done_reg;
    assign PC_OUT = pc_out_reg;
    assign CYCLES = cycles_reg;
    assign PAGE_X = page_x_reg;

`ifdef BRANCH_SEQ_DUMMY_FETCH_EN
    assign DUMMY_RD   = dummy_rd_reg;
    assign DUMMY_ADDR = dummy_addr_reg;
`else
    assign DUMMY_RD   = 1'b0;
    assign DUMMY_ADDR = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_seq.sv
// Directed-vector bench for branch_seq: latency, PC result, cycle count, page cross, stall and reset.
module tb_branch_seq;

    logic        CLK;
    logic        RES;
    logic        BR_START;
    logic        n_BRTAKEN;
    logic [7:0]  OFFSET;
    logic [15:0] PC_IN;
    logic        RDY;
    logic        BUSY;
    logic        DONE;
    logic [15:0] PC_OUT;
    logic [2:0]  CYCLES;
    logic        PAGE_X;
    logic        DUMMY_RD;
    logic [15:0] DUMMY_ADDR;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BRANCH_SEQ_DUMMY_FETCH_EN
    localparam logic DUMMY_EN = 1'b1;
`else
    localparam logic DUMMY_EN = 1'b0;
`endif

    branch_seq dut (
        .CLK        (CLK),
        .RES        (RES),
        .BR_START   (BR_START),
        .n_BRTAKEN  (n_BRTAKEN),
        .OFFSET     (OFFSET),
        .PC_IN      (PC_IN),
        .RDY        (RDY),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .PC_OUT     (PC_OUT),
        .CYCLES     (CYCLES),
        .PAGE_X     (PAGE_X),
        .DUMMY_RD   (DUMMY_RD),
        .DUMMY_ADDR (DUMMY_ADDR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Called at a negedge; returns cycles from the sampling edge until DONE is seen (10 = timed out).
    task automatic issue(input logic [15:0] pc, input logic [7:0] off, input logic nt,
                         output int lat, output logic saw_rd, output logic [15:0] rd_addr);
        saw_rd  = 1'b0;
        rd_addr = 16'h0000;
        BR_START  = 1'b1;
        PC_IN     = pc;
        OFFSET    = off;
        n_BRTAKEN = nt;
        @(posedge CLK);
        @(negedge CLK);
        BR_START = 1'b0;
        lat = 1;
        while (DONE !== 1'b1 && lat < 10) begin
            if (DUMMY_RD === 1'b1) begin
                saw_rd  = 1'b1;
                rd_addr = DUMMY_ADDR;
            end
            @(posedge CLK);
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic test_reset();
        RES = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({BUSY, DONE, PC_OUT, CYCLES, PAGE_X, DUMMY_RD, DUMMY_ADDR} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b pc=%h cyc=%0d px=%b rd=%b addr=%h, want all zero",
                     BUSY, DONE, PC_OUT, CYCLES, PAGE_X, DUMMY_RD, DUMMY_ADDR);
        end
        RES = 1'b0;
        @(negedge CLK);
        $display("test_reset done");
    endtask

    // Runs one branch and checks latency, PC_OUT, CYCLES, PAGE_X and the dummy read trace.
    task automatic test_branch(input string name, input logic [15:0] pc, input logic [7:0] off,
                               input logic nt, input int exp_lat, input logic [15:0] exp_pc,
                               input logic [2:0] exp_cyc, input logic exp_px,
                               input logic [15:0] exp_rd_addr);
        int lat;
        logic saw_rd;
        logic [15:0] rd_addr;
        issue(pc, off, nt, lat, saw_rd, rd_addr);
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (PC_OUT !== exp_pc || CYCLES !== exp_cyc || PAGE_X !== exp_px || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_result: got pc=%h cyc=%0d px=%b busy=%b want pc=%h cyc=%0d px=%b busy=1",
                     name, PC_OUT, CYCLES, PAGE_X, BUSY, exp_pc, exp_cyc, exp_px);
        end
        n_checks++;
        if (saw_rd !== (DUMMY_EN & ~nt) || rd_addr !== (DUMMY_EN ? exp_rd_addr : 16'h0000)) begin
            n_fail++;
            $display("FAIL %s_dummy: got rd=%b addr=%h want rd=%b addr=%h", name, saw_rd, rd_addr,
                     DUMMY_EN & ~nt, DUMMY_EN ? exp_rd_addr : 16'h0000);
        end
        @(negedge CLK);
        n_checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || PC_OUT !== exp_pc || CYCLES !== exp_cyc) begin
            n_fail++;
            $display("FAIL %s_after_done: got done=%b busy=%b pc=%h cyc=%0d want done=0 busy=0 pc=%h cyc=%0d",
                     name, DONE, BUSY, PC_OUT, CYCLES, exp_pc, exp_cyc);
        end
        $display("branch %s: pc_in=%h off=%h nt=%b -> pc_out=%h cyc=%0d px=%b lat=%0d",
                 name, pc, off, nt, PC_OUT, CYCLES, PAGE_X, lat);
    endtask

    // Freeze 3 cycles in FIX, then freeze 2 cycles in DONE.
    task automatic test_stall();
        BR_START = 1'b1; PC_IN = 16'h12F0; OFFSET = 8'h20; n_BRTAKEN = 1'b0;
        @(posedge CLK);              // IDLE -> ADD
        @(negedge CLK);
        BR_START = 1'b0;
        @(posedge CLK);              // ADD -> FIX
        @(negedge CLK);
        RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            n_checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_fix_frozen[%0d]: got done=%b busy=%b want done=0 busy=1", i, DONE, BUSY);
            end
        end
        RDY = 1'b1;
        @(posedge CLK);              // FIX -> DONE
        @(negedge CLK);
        n_checks++;
        if (DONE !== 1'b1 || PC_OUT !== 16'h1310 || CYCLES !== 3'd4 || PAGE_X !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: got done=%b pc=%h cyc=%0d px=%b want done=1 pc=1310 cyc=4 px=1",
                     DONE, PC_OUT, CYCLES, PAGE_X);
        end
        RDY = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            @(negedge CLK);
            n_checks++;
            if (DONE !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_done_held: got done=%b want 1", DONE);
            end
        end
        RDY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got done=%b busy=%b want 0 0", DONE, BUSY);
        end
        $display("test_stall done: pc_out=%h", PC_OUT);
    endtask

    // Reset pulse while in FIX discards the branch; reset also beats a same-cycle start.
    task automatic test_reset_mid();
        BR_START = 1'b1; PC_IN = 16'h12F0; OFFSET = 8'h20; n_BRTAKEN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        BR_START = 1'b0;
        @(posedge CLK);              // now in FIX
        @(negedge CLK);
        RES = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RES = 1'b0;
        n_checks++;
        if ({BUSY, DONE, PC_OUT, CYCLES, PAGE_X, DUMMY_RD, DUMMY_ADDR} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_mid_fix: got busy=%b done=%b pc=%h cyc=%0d px=%b rd=%b addr=%h want all zero",
                     BUSY, DONE, PC_OUT, CYCLES, PAGE_X, DUMMY_RD, DUMMY_ADDR);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            n_checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_done[%0d]: got done=%b busy=%b want 0 0", i, DONE, BUSY);
            end
        end
        RES = 1'b1; BR_START = 1'b1; n_BRTAKEN = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RES = 1'b0; BR_START = 1'b0;
        n_checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_over_start: got busy=%b done=%b want 0 0", BUSY, DONE);
        end
        $display("test_reset_mid done");
    endtask

    // BR_START held high: one not-taken branch, one idle cycle, then the next; input changes while busy are ignored.
    task automatic test_back_to_back();
        BR_START = 1'b1; PC_IN = 16'hA000; OFFSET = 8'h05; n_BRTAKEN = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        PC_IN = 16'hB000;
        n_checks++;
        if (DONE !== 1'b1 || PC_OUT !== 16'hA000) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b pc=%h want done=1 pc=a000", DONE, PC_OUT);
        end
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got done=%b busy=%b want 0 0", DONE, BUSY);
        end
        n_BRTAKEN = 1'b0; PC_IN = 16'h3010; OFFSET = 8'h08;
        @(posedge CLK);              // IDLE -> ADD with 0x3010
        @(negedge CLK);
        PC_IN = 16'h7777; OFFSET = 8'h80;
        @(posedge CLK);              // ADD -> DONE
        @(negedge CLK);
        BR_START = 1'b0;
        n_checks++;
        if (DONE !== 1'b1 || PC_OUT !== 16'h3018 || CYCLES !== 3'd3) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b pc=%h cyc=%0d want done=1 pc=3018 cyc=3",
                     DONE, PC_OUT, CYCLES);
        end
        @(negedge CLK);
        $display("test_back_to_back done: pc_out=%h", PC_OUT);
    endtask

    initial begin
        RES = 1'b1; BR_START = 1'b0; n_BRTAKEN = 1'b1; OFFSET = 8'h00; PC_IN = 16'h0000; RDY = 1'b1;
        test_reset();
        test_branch("not_taken",  16'h1234, 8'h10, 1'b1, 1, 16'h1234, 3'd2, 1'b0, 16'h0000);
        test_branch("fwd_same",   16'h1234, 8'h10, 1'b0, 2, 16'h1244, 3'd3, 1'b0, 16'h1234);
        test_branch("fwd_cross",  16'h12F0, 8'h20, 1'b0, 3, 16'h1310, 3'd4, 1'b1, 16'h1210);
        test_branch("bwd_cross",  16'h1200, 8'hFE, 1'b0, 3, 16'h11FE, 3'd4, 1'b1, 16'h12FE);
        test_branch("bwd_same",   16'h1210, 8'hFE, 1'b0, 2, 16'h120E, 3'd3, 1'b0, 16'h1210);
        test_branch("wrap_up",    16'hFFF0, 8'h20, 1'b0, 3, 16'h0010, 3'd4, 1'b1, 16'hFF10);
        test_branch("wrap_down",  16'h0005, 8'hF0, 1'b0, 3, 16'hFFF5, 3'd4, 1'b1, 16'h00F5);
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have ports: RES  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: BR_START  in  1  decoded conditional-branch opcode, operand byte valid; sampled only in IDLE.
REQ-004 SHALL have ports: n_BRTAKEN  in  1  branch-condition result from flag test, active-low (0 = taken); sampled with BR_START.
REQ-005 SHALL have ports: OFFSET  in  8  signed relative displacement; bit 7 = backward.
REQ-006 SHALL have ports: PC_IN  in  16  address of the instruction following the branch operand.
REQ-007 SHALL have ports: RDY  in  1  1 = advance, 0 = freeze all state and registers.
REQ-008 SHALL have ports: BUSY  out  1  high whenever state != IDLE.
REQ-009 SHALL have ports: DONE  out  1  high while state = DONE.
REQ-010 SHALL have ports: PC_OUT  out  16  next program counter; valid while DONE = 1.
REQ-011 SHALL have ports: CYCLES  out  3  total instruction cycles (2/3/4); valid while DONE = 1.
REQ-012 SHALL have ports: PAGE_X  out  1  target is on a different page than PC_IN; valid while DONE = 1.
REQ-013 SHALL have ports: DUMMY_RD  out  1  dummy bus read strobe.
REQ-014 SHALL have ports: DUMMY_ADDR  out  16  dummy read address.

Function
REQ-015 SHALL implement states IDLE, ADD, FIX and DONE; all transitions are gated by RDY = 1, and RDY = 0 holds state and every register.
REQ-016 In IDLE with BR_START = 1, it SHALL latch PC_IN, OFFSET and n_BRTAKEN, and set BRFW = ~OFFSET[7].
- Next state is DONE if n_BRTAKEN = 1.
- Next state is ADD if n_BRTAKEN = 0.
REQ-017 ADD SHALL compute lo = PC_lo + OFFSET with carry C, and set page-cross X = (BRFW & C) | (~BRFW & ~C).
- If X = 0, next state is DONE.
- If X = 1, next state is FIX.
REQ-018 FIX SHALL set hi = PC_hi + 1 if BRFW, else PC_hi - 1, modulo 256; next state is DONE.
REQ-019 DONE SHALL present outputs, then transition to IDLE.
- BR_START is ignored in every state except IDLE.
- BR_START is not accepted in the same cycle DONE is exited.
REQ-020 PC_OUT SHALL be:
- not taken: PC_IN.
- taken, no page cross: {PC_hi, lo}.
- page cross: {hi, lo}.
- Arithmetic wraps at 0xFFFF/0x0000 with no error indication.
REQ-021 CYCLES SHALL be 2 for not taken, 3 for taken same-page, 4 for taken page-cross; PAGE_X = X for taken, 0 for not taken.
REQ-022 Latency SHALL be measured from the edge sampling BR_START with RDY held at 1; DONE asserts 1, 2 or 3 cycles later for 2, 3 or 4 CYCLES respectively.
REQ-023 DONE SHALL stay high for exactly one cycle when RDY = 1, and for the full duration of the freeze when RDY = 0.
REQ-024 PC_OUT, CYCLES and PAGE_X SHALL hold their last values outside DONE.

Reset
REQ-025 RES = 1 SHALL force state IDLE regardless of RDY or current state, including mid-ADD or mid-FIX.
- On reset: BUSY = 0, DONE = 0, PC_OUT = 0x0000, CYCLES = 0, PAGE_X = 0, DUMMY_RD = 0, DUMMY_ADDR = 0x0000.
- A branch in progress at reset is discarded without producing DONE.
REQ-026 RES SHALL take priority over BR_START in the same cycle.

Configuration
REQ-027 The block SHALL support macro BRANCH_SEQ_DUMMY_FETCH_EN.
- Defined: DUMMY_RD = 1 in ADD and FIX.
- DUMMY_ADDR = PC_IN in ADD.
- DUMMY_ADDR = {PC_hi, lo} in FIX, modelling the 6502 wrong-page read.
- Undefined: DUMMY_RD and DUMMY_ADDR are constant 0.
- All other behaviour is identical with or without the macro.

Verification
REQ-028 Not taken: PC_IN = 0x1234, OFFSET = 0x10, n_BRTAKEN = 1 -> DONE 1 cycle later, PC_OUT = 0x1234, CYCLES = 2, PAGE_X = 0.
REQ-029 Forward same-page: PC_IN = 0x1234, OFFSET = 0x10, taken -> DONE 2 cycles later, PC_OUT = 0x1244, CYCLES = 3.
REQ-030 Forward cross: PC_IN = 0x12F0, OFFSET = 0x20, taken -> PC_OUT = 0x1310, CYCLES = 4, PAGE_X = 1.
- With macro defined: DUMMY_ADDR = 0x1210 in FIX.
REQ-031 Backward cross: PC_IN = 0x1200, OFFSET = 0xFE -> PC_OUT = 0x11FE, CYCLES = 4.
REQ-032 Wrap: PC_IN = 0xFFF0, OFFSET = 0x20 -> PC_OUT = 0x0010, CYCLES = 4.
REQ-033 Stall/reset: RDY = 0 for 3 cycles in FIX -> state frozen and DONE delayed 3 cycles; RES pulse in FIX -> IDLE next cycle, no DONE, outputs at reset values.
